prog_sequencer: RTL
===================

# prog_sequencer

Sequences the single-cycle core through its three benchmark programs (product, string match, closest pair) without a testbench toggling reset between them. It holds the core in reset and forces the `pc` block to each program's entry address, then releases the core and waits for the decoded halt. Each run's cycle count and timeout status is reported before the next program starts. The block sits beside `pc` in the top level and drives the core's reset and PC-load path.

## Interface
- `NUM_PROG`, default 3: number of programs run per sequence (1..4).
- `ENTRY0`, `ENTRY1`, `ENTRY2`, `ENTRY3`, defaults 0, 25, 44, 0: 8-bit entry PC of each program.
- `HOLD_CYCLES`, default 2: cycles the core stays in reset with PC forced before each run (>=1).
- `TIMEOUT_CYC`, default 16'd4000: maximum RUN cycles before a program is abandoned (>=1).

Ports:
- `clk` in 1: single clock. All state updates on posedge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `start` in 1: begin a sequence. Sampled only in IDLE or DONE.
- `halt` in 1: core's decoded halt instruction. Sampled only in RUN.
- `core_reset` out 1: reset to the core datapath.
- `pc_load` out 1: forces `pc` to `pc_target` instead of increment/branch.
- `pc_target` out 8: entry address of the current program.
- `prog_id` out 2: index of the current program.
- `busy` out 1: high in HOLD, RUN and NEXT.
- `result_valid` out 1: one-cycle pulse per finished program.
- `result_id` out 2: program index for this result.
- `result_cycles` out 16: RUN cycles consumed.
- `result_timeout` out 1: program was abandoned on timeout.
- `done` out 1: all programs finished. Level, held in DONE.

## Operation
- States: IDLE, HOLD, RUN, NEXT, DONE.
- IDLE: `core_reset`=1, `busy`=0. When `start`=1, set `prog_id`<=0 and `hold_cnt`<=0, then go to HOLD.
- HOLD: `core_reset`=1, `pc_load`=1, `pc_target`=ENTRY[`prog_id`], and `hold_cnt` increments. When `hold_cnt`==HOLD_CYCLES-1, set `cyc`<=0 and go to RUN.
- RUN: `core_reset`=0, `pc_load`=0, and `cyc` increments every cycle, including the halt cycle.
  - If `halt`=1: latch `cyc+1` and `timeout`=0, then go to NEXT.
  - Else if `cyc+1`==TIMEOUT_CYC: latch TIMEOUT_CYC and `timeout`=1, then go to NEXT.
- NEXT: `core_reset`=1 and `result_valid`=1 with the latched values; `result_id`=`prog_id`.
  - If `prog_id`==NUM_PROG-1, go to DONE.
  - Otherwise `prog_id`<=`prog_id`+1, `hold_cnt`<=0, and go to HOLD.
- DONE: `core_reset`=1, `done`=1. When `start`=1, clear `done`, set `prog_id`<=0, and go to HOLD (restart).
- Simultaneous events:
  - `halt` and timeout in the same RUN cycle: halt wins and `result_timeout`=0.
  - `start` while `busy`: ignored.
  - `halt` outside RUN: ignored.
- `reset` in any state, including mid-RUN, returns to IDLE on the next edge. No result is emitted for the aborted program.
- `pc_target` is ENTRY[`prog_id`] in all states. Only `pc_load` gates its use.

## Timing
- Reset values:
  - State IDLE.
  - `core_reset`=1.
  - `pc_load`=0, `pc_target`=ENTRY0.
  - `prog_id`=0, `busy`=0, `done`=0.
  - `result_valid`=0, `result_id`=0, `result_cycles`=0, `result_timeout`=0.
- All outputs are registered or decoded from the registered state. No combinational path from `halt` or `start` to any output.
- Latency from `start` to the first core-active cycle is 1+HOLD_CYCLES edges.
- Latency from `halt` to `result_valid` is 1 edge. From `result_valid` to the next program's RUN is HOLD_CYCLES+1 edges.
- `result_*` hold their values after the pulse until the next NEXT state or reset.
- `cyc` is 16 bits. TIMEOUT_CYC<=16'hFFFF guarantees no wrap.

## Structure
- Add the `seq_state_t` enum (IDLE, HOLD, RUN, NEXT, DONE) and the default entry constants (PROG_PRODUCT=0, PROG_STRMATCH=25, PROG_CLOSEST=44) to package `definitions`.
- Top level ORs `core_reset` with the external `reset` into `pc.reset`. `pc_load` takes priority over branch/increment in the PC mux.
- No sub-module: the FSM and two counters stay in one file.

## Test plan
- Reset then `start` pulse, with `halt` at RUN cycles 10, 7 and 20:
  - Three `result_valid` pulses with ids 0/1/2 and cycles 10/7/20, all with timeout 0.
  - `done`=1 after the third pulse.
  - `pc_target` reads 0, 25, 44 during the respective HOLD states.
- With TIMEOUT_CYC=50, program 1 never halts: `result_cycles`=50 and `result_timeout`=1 for id 1, and program 2 still runs.
- `halt` on the exact cycle the timeout would fire: `result_cycles`=TIMEOUT_CYC and `result_timeout`=0.
- `reset` asserted at RUN cycle 5 of program 1: IDLE on the next edge, `core_reset`=1, no `result_valid`, and `prog_id`=0.
- `start` pulsed during RUN is ignored. `start` in DONE restarts at id 0 with `done` cleared on the next edge.
- `halt` held high through HOLD: no effect until RUN. In the first RUN cycle it yields `result_cycles`=1.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the program sequencer and its neighbours in the core top level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package definitions;

    // Sequencer states: hold core in reset with PC forced, run, report, finish.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Entry addresses of the three benchmark programs in instruction memory.
    localparam logic [7:0] PROG_PRODUCT  = 8'd0;
    localparam logic [7:0] PROG_STRMATCH = 8'd25;
    localparam logic [7:0] PROG_CLOSEST  = 8'd44;

endpackage

// File: rtl/prog_sequencer.sv
// Runs the core through NUM_PROG programs back to back, reporting cycles/timeout per program.
// Latency: start -> core active in 1+HOLD_CYCLES edges; halt -> result_valid in 1 edge.
// Backpressure: none; start ignored while busy, halt ignored outside RUN, results are fire-and-forget pulses.
//
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   start                : begin a sequence (sampled in IDLE/DONE)
//   halt                 : core's decoded halt (sampled in RUN)
//   core_reset           : reset to the core datapath (low only in RUN)
//   pc_load, pc_target   : force pc to the current program's entry address
//   prog_id              : index of the current program
//   busy, done           : sequence in progress / all programs finished (level)
//   result_valid         : one-cycle pulse per finished program
//   result_id/_cycles/_timeout : held values of the latest finished program
module prog_sequencer
    import definitions::*;
#(
    parameter int          NUM_PROG    = 3,
    parameter logic [7:0]  ENTRY0      = PROG_PRODUCT,
    parameter logic [7:0]  ENTRY1      = PROG_STRMATCH,
    parameter logic [7:0]  ENTRY2      = PROG_CLOSEST,
    parameter logic [7:0]  ENTRY3      = 8'd0,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic        core_reset,
    output logic        pc_load,
    output logic [7:0]  pc_target,
    output logic [1:0]  prog_id,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  result_id,
    output logic [15:0] result_cycles,
    output logic        result_timeout,
    output logic        done
);

    localparam logic [1:0]  LAST_ID   = 2'(NUM_PROG - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] hold_cnt;
    logic [15:0] cyc;
    logic [15:0] cyc_inc;
    logic        last_prog;

    assign cyc_inc   = cyc + 16'd1;
    assign last_prog = (prog_id == LAST_ID);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = HOLD;
            HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
            // Halt and timeout in the same cycle both lead to NEXT; the datapath
            // below gives halt priority for the reported values.
            RUN:  if (halt || (cyc_inc == TIMEOUT_CYC)) state_nxt = NEXT;
            NEXT: state_nxt = last_prog ? DONE : HOLD;
            DONE: if (start) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // Program index, counters and result latches
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_id        <= 2'd0;
            hold_cnt       <= 16'd0;
            cyc            <= 16'd0;
            result_id      <= 2'd0;
            result_cycles  <= 16'd0;
            result_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        prog_id  <= 2'd0;
                        hold_cnt <= 16'd0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 16'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        cyc <= 16'd0;
                    end
                end
                RUN: begin
                    // The halt cycle itself counts as a consumed cycle.
                    cyc <= cyc_inc;
                    if (halt) begin
                        result_id      <= prog_id;
                        result_cycles  <= cyc_inc;
                        result_timeout <= 1'b0;
                    end else if (cyc_inc == TIMEOUT_CYC) begin
                        result_id      <= prog_id;
                        result_cycles  <= TIMEOUT_CYC;
                        result_timeout <= 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_prog) begin
                        prog_id  <= prog_id + 2'd1;
                        hold_cnt <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        core_reset   = (state != RUN);
        pc_load      = (state == HOLD);
        busy         = (state == HOLD) || (state == RUN) || (state == NEXT);
        result_valid = (state == NEXT);
        done         = (state == DONE);
        case (prog_id)
            2'd0:    pc_target = ENTRY0;
            2'd1:    pc_target = ENTRY1;
            2'd2:    pc_target = ENTRY2;
            default: pc_target = ENTRY3;
        endcase
    end

endmodule
